// File: rtl/lc3b_types.sv
// Shared LC-3b types and helpers for the memory stage.
// Provides the opcode encoding, word/register/mask typedefs, the
// memory-stage state enum, the byte-enable mask constants and small
// opcode classification helpers.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } lc3b_mem_state;

  // Bit 1 of a mask enables the high byte.
  localparam lc3b_mem_wmask LC3B_MASK_WORD = 2'b11;
  localparam lc3b_mem_wmask LC3B_MASK_LO   = 2'b01;
  localparam lc3b_mem_wmask LC3B_MASK_HI   = 2'b10;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
           (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic is_load_op(input lc3b_opcode op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
  endfunction

  // LDI and STI both start with a read of the pointer.
  function automatic logic is_first_read(input lc3b_opcode op);
    return is_load_op(op) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering for LC-3b byte accesses (purely combinational).
// Ports:
//   addr_lsb : address bit 0 (1 selects the high byte)
//   opcode   : lc3b_opcode of the access
//   wdata    : store source value
//   rdata    : raw memory read word
//   st_data  : store data (low byte replicated for STB, else wdata)
//   st_mask  : byte enables (one lane for STB, else whole word)
//   ld_data  : load result (sign-extended byte for LDB, else rdata)
module lc3b_byte_lane
  import lc3b_types::*;
(
  input  logic        addr_lsb,
  input  logic [3:0]  opcode,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [15:0] st_data,
  output logic [1:0]  st_mask,
  output logic [15:0] ld_data
);

  lc3b_opcode op;
  logic [7:0] rd_byte;

  assign op = lc3b_opcode'(opcode);

  // The byte is replicated on both lanes so the mask alone picks the target.
  always_comb begin
    st_data = wdata;
    st_mask = LC3B_MASK_WORD;
    if (op == OP_STB) begin
      st_data = {wdata[7:0], wdata[7:0]};
      st_mask = addr_lsb ? LC3B_MASK_HI : LC3B_MASK_LO;
    end
  end

  assign rd_byte = addr_lsb ? rdata[15:8] : rdata[7:0];
  assign ld_data = (op == OP_LDB) ? {{8{rd_byte[7]}}, rd_byte} : rdata;

endmodule

// File: rtl/lc3b_mem_stage.sv
// LC-3b memory-access stage. Sequences LDR/LDB/LDI/STR/STB/STI against a
// single-ported memory with a mem_resp handshake; other ops pass through
// after one register stage. LDI/STI make a second access through the
// pointer returned by the first read.
// Optional feature macro: LC3B_MEM_TIMEOUT_EN (per-access response watchdog
// of TIMEOUT_CYCLES cycles; err stays 0 when undefined).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : upstream handshake
//   in_opcode/addr/wdata/alu   : decoded op, effective address, store data,
//   in_dest/in_ld_regfile        execute result, destination, write enable
//   mem_read/write/address/wdata/byte_enable : registered memory request
//   mem_resp/mem_rdata         : memory completion and read data
//   out_valid/data/dest/ld_regfile : one-cycle result pulse to writeback
//   err                        : one-cycle timeout pulse
module lc3b_mem_stage
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_wdata,
  input  logic [15:0] in_alu,
  input  logic [2:0]  in_dest,
  input  logic        in_ld_regfile,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [2:0]  out_dest,
  output logic        out_ld_regfile,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter (1..255)");
  end

  lc3b_mem_state state_q, state_d;
  lc3b_opcode    in_op, op_q;
  logic          addr_lsb_q;
  lc3b_word      wdata_q;
  lc3b_reg       dest_q;
  logic          ld_q;
  logic          accept;
  logic          timeout;

  logic          lane_lsb;
  logic [3:0]    lane_op;
  lc3b_word      st_data, ld_data;
  lc3b_mem_wmask st_mask;

  logic          mem_read_d, mem_write_d, out_valid_d, out_ld_d, err_d;
  lc3b_word      mem_address_d, mem_wdata_d, out_data_d;
  lc3b_mem_wmask mask_d;
  lc3b_reg       out_dest_d;

  assign in_op    = lc3b_opcode'(in_opcode);
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // In IDLE the lane shapes the incoming store; while accessing it
  // extracts the load result for the latched op.
  assign lane_op  = (state_q == IDLE) ? in_opcode : op_q;
  assign lane_lsb = (state_q == IDLE) ? in_addr[0] : addr_lsb_q;

  lc3b_byte_lane u_byte_lane (
    .addr_lsb (lane_lsb),
    .opcode   (lane_op),
    .wdata    (in_wdata),
    .rdata    (mem_rdata),
    .st_data  (st_data),
    .st_mask  (st_mask),
    .ld_data  (ld_data)
  );

`ifdef LC3B_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // wait_cnt counts cycles already spent waiting in the current access.
  assign timeout = (state_q != IDLE) && !mem_resp &&
                   (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Restart the count whenever a new access begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_d != IDLE && state_d != state_q) begin
      wait_cnt <= '0;
    end else if (state_q != IDLE) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mem_op(in_op)) state_d = ACC1;
      ACC1: begin
        if (mem_resp)     state_d = ((op_q == OP_LDI) || (op_q == OP_STI)) ? ACC2 : IDLE;
        else if (timeout) state_d = IDLE;
      end
      ACC2: if (mem_resp || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered request and result outputs. Requests
  // hold their value until the responding cycle; results are one-cycle.
  always_comb begin
    mem_read_d    = mem_read;
    mem_write_d   = mem_write;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;
    mask_d        = mem_byte_enable;
    out_valid_d   = 1'b0;
    out_data_d    = out_data;
    out_dest_d    = '0;
    out_ld_d      = 1'b0;
    err_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mem_op(in_op)) begin
          mem_read_d    = is_first_read(in_op);
          mem_write_d   = !is_first_read(in_op);
          mem_address_d = {in_addr[15:1], 1'b0};
          mem_wdata_d   = st_data;
          mask_d        = st_mask;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_alu;
          out_dest_d  = in_dest;
          out_ld_d    = in_ld_regfile;
        end
      end
      ACC1, ACC2: begin
        if (mem_resp && state_q == ACC1 && (op_q == OP_LDI || op_q == OP_STI)) begin
          mem_read_d    = (op_q == OP_LDI);
          mem_write_d   = (op_q == OP_STI);
          mem_address_d = {mem_rdata[15:1], 1'b0};
          mem_wdata_d   = wdata_q;
          mask_d        = LC3B_MASK_WORD;
        end else if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = is_load_op(op_q) ? ld_data : '0;
          out_dest_d  = dest_q;
          out_ld_d    = is_load_op(op_q) && ld_q;
        end else if (timeout) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_dest_d  = dest_q;
          err_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and operand registers; operands are captured on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= 2'b00;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_dest        <= '0;
      out_ld_regfile  <= 1'b0;
      err             <= 1'b0;
      op_q            <= OP_BR;
      addr_lsb_q      <= 1'b0;
      wdata_q         <= '0;
      dest_q          <= '0;
      ld_q            <= 1'b0;
    end else begin
      mem_read        <= mem_read_d;
      mem_write       <= mem_write_d;
      mem_address     <= mem_address_d;
      mem_wdata       <= mem_wdata_d;
      mem_byte_enable <= mask_d;
      out_valid       <= out_valid_d;
      out_data        <= out_data_d;
      out_dest        <= out_dest_d;
      out_ld_regfile  <= out_ld_d;
      err             <= err_d;
      if (accept) begin
        op_q       <= in_op;
        addr_lsb_q <= in_addr[0];
        wdata_q    <= in_wdata;
        dest_q     <= in_dest;
        ld_q       <= in_ld_regfile;
      end
    end
  end

endmodule

// File: tb/tb_lc3b_mem_stage.sv
// Directed self-checking bench for lc3b_mem_stage.
module tb_lc3b_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = 4'h0;
  logic [15:0] in_addr = '0;
  logic [15:0] in_wdata = '0;
  logic [15:0] in_alu = '0;
  logic [2:0]  in_dest = '0;
  logic        in_ld_regfile = 1'b0;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic        out_ld_regfile;
  logic        err;

  int nChecks = 0;
  int nErrors = 0;

  localparam logic [3:0] ADD = 4'h1, LDB = 4'h2, STB = 4'h3, LDR = 4'h6,
                         STR = 4'h7, LDI = 4'hA, STI = 4'hB, BR = 4'h0;

  lc3b_mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_addr         (in_addr),
    .in_wdata        (in_wdata),
    .in_alu          (in_alu),
    .in_dest         (in_dest),
    .in_ld_regfile   (in_ld_regfile),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_dest        (out_dest),
    .out_ld_regfile  (out_ld_regfile),
    .err             (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] addr,
                               input logic [15:0] wd, input logic [15:0] alu,
                               input logic [2:0] dest, input logic ld);
    in_valid      = v;
    in_opcode     = op;
    in_addr       = addr;
    in_wdata      = wd;
    in_alu        = alu;
    in_dest       = dest;
    in_ld_regfile = ld;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    applyStimulus(1'b0, BR, 16'hFFFF, 16'hDEAD, 16'hCAFE, 3'd7, 1'b1);
  endtask

  initial begin
    // Reset state
    #3;
    checkOutput("rst_mem_read", 16'(mem_read), 16'h0);
    checkOutput("rst_mem_write", 16'(mem_write), 16'h0);
    checkOutput("rst_mem_address", mem_address, 16'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
    checkOutput("rst_mask", 16'(mem_byte_enable), 16'h0);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_out_data", out_data, 16'h0);
    checkOutput("rst_out_dest", 16'(out_dest), 16'h0);
    checkOutput("rst_err", 16'(err), 16'h0);
    #10 rst_n = 1'b1;
    nextCycle;
    checkOutput("rst_in_ready", 16'(in_ready), 16'h1);

    // ADD passes through in one cycle
    applyStimulus(1'b1, ADD, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("add_out_valid", 16'(out_valid), 16'h1);
    checkOutput("add_out_data", out_data, 16'h1234);
    checkOutput("add_out_dest", 16'(out_dest), 16'h3);
    checkOutput("add_out_ld", 16'(out_ld_regfile), 16'h1);
    checkOutput("add_no_req", {14'h0, mem_read, mem_write}, 16'h0);
    checkOutput("add_in_ready", 16'(in_ready), 16'h1);
    nextCycle;
    checkOutput("add_pulse_end", 16'(out_valid), 16'h0);
    checkOutput("add_dest_zero", 16'(out_dest), 16'h0);

    // mem_resp in IDLE is ignored
    mem_resp = 1'b1; mem_rdata = 16'h7777;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("idle_resp_no_valid", 16'(out_valid), 16'h0);
    checkOutput("idle_resp_ready", 16'(in_ready), 16'h1);

    // LDB odd address, response three cycles after accept
    applyStimulus(1'b1, LDB, 16'h3001, 16'h0000, 16'h0000, 3'd2, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("ldb_read", 16'(mem_read), 16'h1);
    checkOutput("ldb_addr", mem_address, 16'h3000);
    checkOutput("ldb_mask", 16'(mem_byte_enable), 16'h3);
    checkOutput("ldb_ready_t1", 16'(in_ready), 16'h0);
    nextCycle;
    checkOutput("ldb_hold_read", 16'(mem_read), 16'h1);
    checkOutput("ldb_hold_addr", mem_address, 16'h3000);
    checkOutput("ldb_ready_t2", 16'(in_ready), 16'h0);
    nextCycle;
    mem_resp = 1'b1; mem_rdata = 16'h80FF;
    checkOutput("ldb_read_resp_cycle", 16'(mem_read), 16'h1);
    checkOutput("ldb_ready_t3", 16'(in_ready), 16'h0);
    checkOutput("ldb_no_early_valid", 16'(out_valid), 16'h0);
    nextCycle;
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    checkOutput("ldb_read_drop", 16'(mem_read), 16'h0);
    checkOutput("ldb_out_valid", 16'(out_valid), 16'h1);
    checkOutput("ldb_out_data", out_data, 16'hFF80);
    checkOutput("ldb_out_dest", 16'(out_dest), 16'h2);
    checkOutput("ldb_out_ld", 16'(out_ld_regfile), 16'h1);
    checkOutput("ldb_ready_after", 16'(in_ready), 16'h1);
    nextCycle;

    // STB low lane, then high lane accepted while out_valid is high
    applyStimulus(1'b1, STB, 16'h4000, 16'hAB5C, 16'h0000, 3'd1, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("stb_write", 16'(mem_write), 16'h1);
    checkOutput("stb_no_read", 16'(mem_read), 16'h0);
    checkOutput("stb_wdata", mem_wdata, 16'h5C5C);
    checkOutput("stb_mask_lo", 16'(mem_byte_enable), 16'h1);
    checkOutput("stb_addr", mem_address, 16'h4000);
    mem_resp = 1'b1;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("stb_out_valid", 16'(out_valid), 16'h1);
    checkOutput("stb_out_ld", 16'(out_ld_regfile), 16'h0);
    checkOutput("stb_write_drop", 16'(mem_write), 16'h0);
    checkOutput("stb_b2b_ready", 16'(in_ready), 16'h1);
    applyStimulus(1'b1, STB, 16'h4001, 16'hAB5C, 16'h0000, 3'd1, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("stb_hi_write", 16'(mem_write), 16'h1);
    checkOutput("stb_mask_hi", 16'(mem_byte_enable), 16'h2);
    checkOutput("stb_hi_addr", mem_address, 16'h4000);
    checkOutput("stb_hi_wdata", mem_wdata, 16'h5C5C);
    mem_resp = 1'b1;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("stb_hi_out_valid", 16'(out_valid), 16'h1);
    nextCycle;

    // STR full word, unaligned address bit ignored
    applyStimulus(1'b1, STR, 16'h2003, 16'h9ABC, 16'h0000, 3'd4, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("str_addr", mem_address, 16'h2002);
    checkOutput("str_wdata", mem_wdata, 16'h9ABC);
    checkOutput("str_mask", 16'(mem_byte_enable), 16'h3);
    mem_resp = 1'b1;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("str_out_ld", 16'(out_ld_regfile), 16'h0);
    checkOutput("str_out_valid", 16'(out_valid), 16'h1);

    // LDR back-to-back on the result cycle, word passthrough
    applyStimulus(1'b1, LDR, 16'h2005, 16'h0000, 16'h0000, 3'd6, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("ldr_addr", mem_address, 16'h2004);
    mem_resp = 1'b1; mem_rdata = 16'h8421;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("ldr_out_data", out_data, 16'h8421);
    checkOutput("ldr_out_dest", 16'(out_dest), 16'h6);
    nextCycle;

    // LDI double access
    applyStimulus(1'b1, LDI, 16'h5000, 16'h0000, 16'h0000, 3'd5, 1'b1);
    nextCycle;
    idleInputs;
    checkOutput("ldi_read1", 16'(mem_read), 16'h1);
    checkOutput("ldi_addr1", mem_address, 16'h5000);
    mem_resp = 1'b1; mem_rdata = 16'h6001;
    nextCycle;
    checkOutput("ldi_read2", 16'(mem_read), 16'h1);
    checkOutput("ldi_addr2", mem_address, 16'h6000);
    checkOutput("ldi_no_mid_valid", 16'(out_valid), 16'h0);
    checkOutput("ldi_ready_acc2", 16'(in_ready), 16'h0);
    mem_rdata = 16'hBEEF;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("ldi_out_valid", 16'(out_valid), 16'h1);
    checkOutput("ldi_out_data", out_data, 16'hBEEF);
    checkOutput("ldi_out_ld", 16'(out_ld_regfile), 16'h1);
    checkOutput("ldi_out_dest", 16'(out_dest), 16'h5);
    checkOutput("ldi_read_drop", 16'(mem_read), 16'h0);
    nextCycle;

    // STI interrupted by reset during the second access
    applyStimulus(1'b1, STI, 16'h7000, 16'h1357, 16'h0000, 3'd2, 1'b0);
    nextCycle;
    idleInputs;
    checkOutput("sti_read1", 16'(mem_read), 16'h1);
    mem_resp = 1'b1; mem_rdata = 16'h8001;
    nextCycle;
    mem_resp = 1'b0;
    checkOutput("sti_write2", 16'(mem_write), 16'h1);
    checkOutput("sti_read_off", 16'(mem_read), 16'h0);
    checkOutput("sti_addr2", mem_address, 16'h8000);
    checkOutput("sti_wdata2", mem_wdata, 16'h1357);
    checkOutput("sti_mask2", 16'(mem_byte_enable), 16'h3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("sti_async_drop", 16'(mem_write), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle;
    checkOutput("sti_no_valid", 16'(out_valid), 16'h0);
    checkOutput("sti_ready_after", 16'(in_ready), 16'h1);
    checkOutput("sti_write_idle", 16'(mem_write), 16'h0);
    nextCycle;
    checkOutput("sti_no_valid_later", 16'(out_valid), 16'h0);

`ifdef LC3B_MEM_TIMEOUT_EN
    // LDR whose response never comes
    applyStimulus(1'b1, LDR, 16'h1000, 16'h0000, 16'h0000, 3'd3, 1'b1);
    nextCycle;
    idleInputs;
    repeat (254) nextCycle;
    checkOutput("to_still_waiting", 16'(mem_read), 16'h1);
    checkOutput("to_no_err_yet", 16'(err), 16'h0);
    nextCycle;
    checkOutput("to_err", 16'(err), 16'h1);
    checkOutput("to_out_valid", 16'(out_valid), 16'h1);
    checkOutput("to_out_ld", 16'(out_ld_regfile), 16'h0);
    checkOutput("to_read_drop", 16'(mem_read), 16'h0);
    checkOutput("to_ready", 16'(in_ready), 16'h1);
    nextCycle;
    checkOutput("to_err_pulse", 16'(err), 16'h0);
`else
    checkOutput("err_tied_low", 16'(err), 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
